pe_row_gen: RTL and testbench
=============================

PE_ROW_GEN -- requirements
Module: pe_row_gen

Interface
REQ-001 Parameter NUM_PE, default 4, number of PEs in the row (min 2); PE_0..PE_{NUM_PE-2} SHALL be PE_A and the last PE SHALL be PE_B.
REQ-002 Parameter DATA_W, default 32, datapath width of every PE port.
REQ-003 Parameter CNT_W, default 16, width of the run iteration counter.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 cfg_start  input  1  pulse: begin a (re)load of LSU and all PEs.
REQ-007 cfg_valid / cfg_ready  input / output  1 / 1  configuration word handshake.
REQ-008 cfg_data  input  `PE_inst  configuration word; low `L_I_W bits are the LSU instruction.
REQ-009 cfg_par  input  1  even parity over cfg_data (used only under REQ-031).
REQ-010 run_req  input  1  pulse: start a run.
REQ-011 run_abort  input  1  pulse: stop a run early.
REQ-012 iter_count  input  CNT_W  run length in cycles, sampled with run_req.
REQ-013 CBG_to_LSU_bus  input  `C_L_bus  LSU data from the CBG.
REQ-014 S_in / S_out  input / output  NUM_PE*DATA_W  south ports; slice i belongs to PE_i.
REQ-015 R_request / W_request / LSU_addr_bus  output  `R_Q / `W_Q / `A_bus  passed through from the LSU.
REQ-016 cfg_done, busy, run_done, cfg_err  output  1 each  status (see Function).

Function
REQ-017 Row wiring SHALL be: LSU output to PE_0 west input; PE_0 west output to LSU PE_in; PE_i east output to PE_{i+1} west input; PE_{i+1} west output to PE_i east input.
REQ-018 The FSM SHALL have four states: IDLE, LOAD, READY, RUN.
REQ-019 IDLE->LOAD on cfg_start; READY->LOAD on cfg_start; cfg_start SHALL be ignored in LOAD and RUN.
REQ-020 In LOAD, cfg_ready SHALL be 1 and a word SHALL be accepted on each cycle with cfg_valid&cfg_ready; outside LOAD, cfg_ready SHALL be 0.
REQ-021 Word k (k=0 targets the LSU, k=1..NUM_PE targets PE_{k-1}) SHALL be registered and presented on PE_config with a one-cycle init pulse to that target only, exactly 1 cycle after acceptance.
REQ-022 After word NUM_PE is accepted, the FSM SHALL enter READY on the next cycle; the last init pulse SHALL coincide with that cycle.
REQ-023 cfg_done SHALL be 1 in READY and RUN, SHALL clear on entry to LOAD, and SHALL be 0 in IDLE.
REQ-024 READY->RUN on run_req with iter_count!=0, loading the counter with iter_count; run_req with iter_count==0 SHALL be ignored; run_req outside READY SHALL be ignored.
REQ-025 In RUN, run SHALL be 1 to the LSU and all PEs for exactly iter_count cycles; busy SHALL be 1 in LOAD and RUN.
REQ-026 When the counter expires, the FSM SHALL go RUN->READY and run_done SHALL pulse 1 cycle, in the first READY cycle.
REQ-027 run_abort in RUN SHALL return the FSM to READY next cycle without pulsing run_done; if run_abort coincides with the final count, the abort SHALL win.
REQ-028 The counter SHALL not wrap; the maximum run length SHALL be 2^CNT_W-1 cycles.

Reset
REQ-029 While rst=0: state IDLE, counter 0, config register 0, cfg_ready/cfg_done/busy/run_done/cfg_err/run/init all 0; this SHALL hold even when reset is asserted in the middle of a LOAD or RUN.
REQ-030 PE and LSU internal state SHALL reset through their own rst ports, driven by the same signal.

Configuration
REQ-031 With PE_ROW_CFG_PARITY_EN defined: a word whose cfg_par mismatches the even parity of cfg_data SHALL generate no init pulse, SHALL set sticky cfg_err, and SHALL return the FSM to IDLE; cfg_err SHALL clear on cfg_start. Without the macro, cfg_par SHALL be ignored and cfg_err SHALL be tied to 0.

Structure
REQ-032 FSM state encoding and the row-level constants (target-index width clog2(NUM_PE+1)) SHALL live in the shared package/param_define.v alongside `PE_inst and `L_I_W.
REQ-033 Sequencing (FSM, word index, iteration counter, parity check) SHALL be one sub-module, pe_row_seq; PEs and the LSU SHALL be instantiated in a generate loop.

Verification
REQ-034 NUM_PE=4: cfg_start, then 5 words 0x11..0x15 back-to-back -> init pulses LSU, PE_0..PE_3 on consecutive cycles, each 1 cycle after its handshake; cfg_done=1 on the cycle after the 5th word.
REQ-035 cfg_valid gapped (1 idle cycle between words) -> no init pulses in the gaps; still exactly 5 pulses.
REQ-036 READY, run_req with iter_count=3 -> run high exactly 3 cycles, run_done pulses once on the next cycle; run_req with iter_count=0 -> no run.
REQ-037 RUN with iter_count=10, run_abort on the 4th run cycle -> run low next cycle, no run_done, FSM in READY.
REQ-038 rst asserted after word 2 of a load -> all outputs 0 immediately (asynchronously); a subsequent full load succeeds.
REQ-039 With PE_ROW_CFG_PARITY_EN: a bad-parity 3rd word -> no init for PE_1, cfg_err=1, FSM in IDLE; next cfg_start clears cfg_err.

Source files
------------

// File: rtl/pe_row_gen_pkg.sv
// Shared types and row-level constants for the PE row generator.
// Bus widths here stand in for the PE_inst / L_I_W / C_L_bus / R_Q / W_Q / A_bus defines.
package pe_row_gen_pkg;

  localparam int PE_INST_W = 32;
  localparam int L_I_W     = 16;
  localparam int C_L_BUS_W = 32;
  localparam int R_Q_W     = 1;
  localparam int W_Q_W     = 1;
  localparam int A_BUS_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // Word index covers the LSU plus every PE in the row.
  function automatic int idx_width(input int num_pe);
    return $clog2(num_pe + 1);
  endfunction

  function automatic logic [63:0] alu_op(input logic [1:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
    unique case (op)
      2'd0:    return a + b;
      2'd1:    return a ^ b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

endpackage

// File: rtl/pe_row_gen_if.sv
// Configuration / run-control bus of the PE row: master drives requests, slave reports status.
interface pe_row_gen_if
  import pe_row_gen_pkg::*;
#(
  parameter int CNT_W = 16
) ();
  logic                 cfg_start;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [PE_INST_W-1:0] cfg_data;
  logic                 cfg_par;
  logic                 run_req;
  logic                 run_abort;
  logic [CNT_W-1:0]     iter_count;
  logic                 cfg_done;
  logic                 busy;
  logic                 run_done;
  logic                 cfg_err;

  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_par, run_req, run_abort, iter_count,
    input  cfg_ready, cfg_done, busy, run_done, cfg_err
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, cfg_par, run_req, run_abort, iter_count,
    output cfg_ready, cfg_done, busy, run_done, cfg_err
  );
endinterface

// File: rtl/pe_row_gen_cells.sv
// Row cells: the LSU and the two PE flavours (PE_A passes east/west, PE_B terminates the row).
module pe_row_lsu
  import pe_row_gen_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_init,
  input  logic                 i_run,
  input  logic [L_I_W-1:0]     i_instr,
  input  logic [C_L_BUS_W-1:0] i_cbg,
  input  logic [DATA_W-1:0]    i_pe_in,
  output logic [DATA_W-1:0]    o_pe_out,
  output logic [R_Q_W-1:0]     o_r_req,
  output logic [W_Q_W-1:0]     o_w_req,
  output logic [A_BUS_W-1:0]   o_addr
);
  logic [2:0]         r_mode;
  logic [A_BUS_W-1:0] r_addr;
  logic [DATA_W-1:0]  r_pe_out;
  logic               r_rq;
  logic               r_wq;

  // Mode bits: [0] read, [1] write, [2] merge PE feedback; upper bits seed the address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode   <= '0;
      r_addr   <= '0;
      r_pe_out <= '0;
      r_rq     <= 1'b0;
      r_wq     <= 1'b0;
    end else begin
      r_rq <= 1'b0;
      r_wq <= 1'b0;
      if (i_init) begin
        r_mode <= i_instr[2:0];
        r_addr <= A_BUS_W'(i_instr[L_I_W-1:3]);
      end else if (i_run) begin
        r_rq     <= r_mode[0];
        r_wq     <= r_mode[1];
        r_addr   <= r_addr + A_BUS_W'(1);
        r_pe_out <= r_mode[2] ? (DATA_W'(i_cbg) ^ i_pe_in) : DATA_W'(i_cbg);
      end
    end
  end

  assign o_pe_out = r_pe_out;
  assign o_r_req  = R_Q_W'(r_rq);
  assign o_w_req  = W_Q_W'(r_wq);
  assign o_addr   = r_addr;
endmodule

module pe_row_pe_a
  import pe_row_gen_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_init,
  input  logic                 i_run,
  input  logic [PE_INST_W-1:0] i_config,
  input  logic [DATA_W-1:0]    i_west,
  output logic [DATA_W-1:0]    o_west,
  input  logic [DATA_W-1:0]    i_east,
  output logic [DATA_W-1:0]    o_east,
  input  logic [DATA_W-1:0]    i_south,
  output logic [DATA_W-1:0]    o_south
);
  logic [PE_INST_W-1:0] r_cfg;
  logic [DATA_W-1:0]    r_west, r_east, r_south;
  logic [DATA_W-1:0]    w_alu;

  assign w_alu = DATA_W'(alu_op(r_cfg[1:0], 64'(i_west), 64'(i_south)))
                 ^ DATA_W'(r_cfg[PE_INST_W-1:2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg   <= '0;
      r_west  <= '0;
      r_east  <= '0;
      r_south <= '0;
    end else if (i_init) begin
      r_cfg <= i_config;
    end else if (i_run) begin
      r_south <= w_alu;
      r_east  <= i_west;
      r_west  <= i_east;
    end
  end

  assign o_west  = r_west;
  assign o_east  = r_east;
  assign o_south = r_south;
endmodule

module pe_row_pe_b
  import pe_row_gen_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_init,
  input  logic                 i_run,
  input  logic [PE_INST_W-1:0] i_config,
  input  logic [DATA_W-1:0]    i_west,
  output logic [DATA_W-1:0]    o_west,
  input  logic [DATA_W-1:0]    i_south,
  output logic [DATA_W-1:0]    o_south
);
  logic [PE_INST_W-1:0] r_cfg;
  logic [DATA_W-1:0]    r_west, r_south;
  logic [DATA_W-1:0]    w_alu;

  assign w_alu = DATA_W'(alu_op(r_cfg[1:0], 64'(i_west), 64'(i_south)))
                 ^ DATA_W'(r_cfg[PE_INST_W-1:2]);

  // Last PE reflects its result back west so the row forms a return path to the LSU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg   <= '0;
      r_west  <= '0;
      r_south <= '0;
    end else if (i_init) begin
      r_cfg <= i_config;
    end else if (i_run) begin
      r_south <= w_alu;
      r_west  <= w_alu;
    end
  end

  assign o_west  = r_west;
  assign o_south = r_south;
endmodule

// File: rtl/pe_row_gen_seq.sv
// Row sequencer: load FSM, word index, run counter and (with PE_ROW_CFG_PARITY_EN)
// the configuration parity check.
module pe_row_seq
  import pe_row_gen_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pe_row_gen_if.slave          bus,
  output logic [NUM_PE:0]      o_init,
  output logic                 o_run,
  output logic [PE_INST_W-1:0] o_pe_config
);
  localparam int IDX_W  = idx_width(NUM_PE);
  localparam int INIT_W = NUM_PE + 1;

  state_e               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic [PE_INST_W-1:0] r_cfg_word;
  logic [NUM_PE:0]      r_init;
  logic                 r_run_done;
  logic                 w_accept;
  logic                 w_start_ok;
  logic                 w_par_bad;

  assign w_accept   = (r_state == ST_LOAD) && bus.cfg_valid;
  assign w_start_ok = bus.cfg_start && ((r_state == ST_IDLE) || (r_state == ST_READY));

`ifdef PE_ROW_CFG_PARITY_EN
  logic r_cfg_err;

  assign w_par_bad   = (^bus.cfg_data) != bus.cfg_par;
  assign bus.cfg_err = r_cfg_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_cfg_err <= 1'b0;
    else if (w_start_ok)            r_cfg_err <= 1'b0;
    else if (w_accept && w_par_bad) r_cfg_err <= 1'b1;
  end
`else
  assign w_par_bad   = 1'b0;
  assign bus.cfg_err = 1'b0;
`endif

  // NOTE: every state register uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_cfg_word <= '0;
      r_init     <= '0;
      r_run_done <= 1'b0;
    end else begin
      r_init     <= '0;
      r_run_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
          end
        end
        ST_LOAD: begin
          if (w_accept && w_par_bad) begin
            r_state <= ST_IDLE;
          end else if (w_accept) begin
            r_cfg_word <= bus.cfg_data;
            r_init     <= INIT_W'(1) << r_idx;
            r_idx      <= r_idx + IDX_W'(1);
            if (r_idx == IDX_W'(NUM_PE)) r_state <= ST_READY;
          end
        end
        ST_READY: begin
          if (w_start_ok) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
          end else if (bus.run_req && (bus.iter_count != '0)) begin
            r_state <= ST_RUN;
            r_cnt   <= bus.iter_count;
          end
        end
        ST_RUN: begin
          // Abort outranks the final count so no run_done follows an abort.
          if (bus.run_abort) begin
            r_state <= ST_READY;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(1)) begin
            r_state    <= ST_READY;
            r_cnt      <= '0;
            r_run_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cfg_ready = (r_state == ST_LOAD);
  assign bus.busy      = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign bus.cfg_done  = (r_state == ST_READY) || (r_state == ST_RUN);
  assign bus.run_done  = r_run_done;
  assign o_run         = (r_state == ST_RUN);
  assign o_init        = r_init;
  assign o_pe_config   = r_cfg_word;

endmodule

// File: rtl/pe_row_gen.sv
// PE row top: sequencer, LSU and NUM_PE processing elements chained west-to-east.
// Optional parity check on configuration words: define PE_ROW_CFG_PARITY_EN.
module pe_row_gen
  import pe_row_gen_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  pe_row_gen_if.slave              bus,
  input  logic [NUM_PE*DATA_W-1:0] S_in,
  output logic [NUM_PE*DATA_W-1:0] S_out,
  input  logic [C_L_BUS_W-1:0]     CBG_to_LSU_bus,
  output logic [R_Q_W-1:0]         R_request,
  output logic [W_Q_W-1:0]         W_request,
  output logic [A_BUS_W-1:0]       LSU_addr_bus
);
  logic [NUM_PE:0]      w_init;
  logic                 w_run;
  logic [PE_INST_W-1:0] w_pe_config;
  logic [DATA_W-1:0]    w_lsu_to_pe;
  logic [DATA_W-1:0]    w_west_in  [NUM_PE];
  logic [DATA_W-1:0]    w_west_out [NUM_PE];
  logic [DATA_W-1:0]    w_east_in  [NUM_PE-1];
  logic [DATA_W-1:0]    w_east_out [NUM_PE-1];

  pe_row_seq #(.NUM_PE(NUM_PE), .CNT_W(CNT_W)) u_seq (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_init      (w_init),
    .o_run       (w_run),
    .o_pe_config (w_pe_config)
  );

  pe_row_lsu #(.DATA_W(DATA_W)) u_lsu (
    .clk      (clk),
    .rst      (rst),
    .i_init   (w_init[0]),
    .i_run    (w_run),
    .i_instr  (w_pe_config[L_I_W-1:0]),
    .i_cbg    (CBG_to_LSU_bus),
    .i_pe_in  (w_west_out[0]),
    .o_pe_out (w_lsu_to_pe),
    .o_r_req  (R_request),
    .o_w_req  (W_request),
    .o_addr   (LSU_addr_bus)
  );

  assign w_west_in[0] = w_lsu_to_pe;

  for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
    if (i < NUM_PE - 1) begin : g_a
      pe_row_pe_a #(.DATA_W(DATA_W)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .i_init   (w_init[i+1]),
        .i_run    (w_run),
        .i_config (w_pe_config),
        .i_west   (w_west_in[i]),
        .o_west   (w_west_out[i]),
        .i_east   (w_east_in[i]),
        .o_east   (w_east_out[i]),
        .i_south  (S_in[i*DATA_W +: DATA_W]),
        .o_south  (S_out[i*DATA_W +: DATA_W])
      );
      assign w_west_in[i+1] = w_east_out[i];
      assign w_east_in[i]   = w_west_out[i+1];
    end else begin : g_b
      pe_row_pe_b #(.DATA_W(DATA_W)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .i_init   (w_init[i+1]),
        .i_run    (w_run),
        .i_config (w_pe_config),
        .i_west   (w_west_in[i]),
        .o_west   (w_west_out[i]),
        .i_south  (S_in[i*DATA_W +: DATA_W]),
        .o_south  (S_out[i*DATA_W +: DATA_W])
      );
    end
  end

endmodule

// File: tb/tb_pe_row_gen.sv
// Bench for pe_row_gen: a cycle model of the load/run rules checked every cycle,
// plus hand-computed expectations for the directed loads, runs, aborts and reset.
module tb_pe_row_gen;
  import pe_row_gen_pkg::*;

  localparam int NUM_PE = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
`ifdef PE_ROW_CFG_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_LOAD = 1, M_READY = 2, M_RUN = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_PE*DATA_W-1:0] s_in;
  logic [NUM_PE*DATA_W-1:0] s_out;
  logic [C_L_BUS_W-1:0]     cbg;
  logic [R_Q_W-1:0]         r_req;
  logic [W_Q_W-1:0]         w_req;
  logic [A_BUS_W-1:0]       addr;

  pe_row_gen_if #(.CNT_W(CNT_W)) bus ();

  pe_row_gen #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .S_in           (s_in),
    .S_out          (s_out),
    .CBG_to_LSU_bus (cbg),
    .R_request      (r_req),
    .W_request      (w_req),
    .LSU_addr_bus   (addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: phase of the row, words still expected, cycles of run remaining.
  int             m_state = M_IDLE;
  int             m_word = 0;
  int             m_left = 0;
  int             m_init_tgt = -1;
  logic [31:0]    m_cfg_word = '0;
  bit             m_run_done = 1'b0;
  bit             m_err = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = M_IDLE; m_word = 0; m_left = 0; m_init_tgt = -1;
      m_cfg_word = '0; m_run_done = 1'b0; m_err = 1'b0;
    end else begin
      m_init_tgt = -1;
      m_run_done = 1'b0;
      case (m_state)
        M_IDLE: if (bus.cfg_start) begin m_state = M_LOAD; m_word = 0; m_err = 1'b0; end
        M_LOAD: if (bus.cfg_valid) begin
          if (PARITY_ON && ((^bus.cfg_data) != bus.cfg_par)) begin
            m_state = M_IDLE; m_err = 1'b1;
          end else begin
            m_init_tgt = m_word; m_cfg_word = bus.cfg_data; m_word++;
            if (m_word == NUM_PE + 1) m_state = M_READY;
          end
        end
        M_READY: begin
          if (bus.cfg_start) begin m_state = M_LOAD; m_word = 0; m_err = 1'b0; end
          else if (bus.run_req && bus.iter_count != 0) begin
            m_state = M_RUN; m_left = int'(bus.iter_count);
          end
        end
        M_RUN: begin
          if (bus.run_abort) m_state = M_READY;
          else begin
            m_left--;
            if (m_left == 0) begin m_state = M_READY; m_run_done = 1'b1; end
          end
        end
        default: ;
      endcase
    end
  end

  // Single compare process: every output against the model, every cycle.
  always @(negedge clk) begin
    check("cfg_ready", bus.cfg_ready, m_state == M_LOAD);
    check("busy", bus.busy, (m_state == M_LOAD) || (m_state == M_RUN));
    check("cfg_done", bus.cfg_done, (m_state == M_READY) || (m_state == M_RUN));
    check("run", dut.w_run, m_state == M_RUN);
    check("run_done", bus.run_done, m_run_done);
    check("cfg_err", bus.cfg_err, m_err);
    check("init", dut.w_init, (m_init_tgt < 0) ? 0 : (64'd1 << m_init_tgt));
    check("pe_config", dut.w_pe_config, m_cfg_word);
  end

  // Event monitor for the hand-computed expectations.
  int pulse_cnt [NUM_PE+1];
  int pulse_cyc [NUM_PE+1];
  int hs_cyc    [NUM_PE+1];
  int snap_cnt  [NUM_PE+1];
  int run_cnt = 0, done_cnt = 0, last_run_cyc = 0, done_cyc = 0;
  int snap_run = 0, snap_done = 0;

  initial for (int k = 0; k <= NUM_PE; k++) begin pulse_cnt[k] = 0; pulse_cyc[k] = 0; end

  always @(negedge clk) begin
    for (int k = 0; k <= NUM_PE; k++)
      if (dut.w_init[k]) begin pulse_cnt[k]++; pulse_cyc[k] = cyc; end
    if (dut.w_run) begin run_cnt++; last_run_cyc = cyc; end
    if (bus.run_done) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic snap();
    for (int k = 0; k <= NUM_PE; k++) snap_cnt[k] = pulse_cnt[k];
    snap_run  = run_cnt;
    snap_done = done_cnt;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // cfg_start, then nwords words base+k; word bad_idx carries wrong parity.
  task automatic load(input logic [31:0] base, input int gap, input int bad_idx, input int nwords);
    logic [31:0] w;
    @(negedge clk); bus.cfg_start = 1'b1;
    @(negedge clk); bus.cfg_start = 1'b0;
    for (int k = 0; k < nwords; k++) begin
      w = base + 32'(k);
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = w;
      bus.cfg_par   = (^w) ^ (k == bad_idx);
      hs_cyc[k]     = cyc;
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic run(input int n, input int abort_at);
    @(negedge clk); bus.run_req = 1'b1; bus.iter_count = CNT_W'(n);
    @(negedge clk); bus.run_req = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(negedge clk);
      bus.run_abort = 1'b1;
      @(negedge clk); bus.run_abort = 1'b0;
    end
  endtask

  task automatic check_full_load(input string tag);
    for (int k = 0; k <= NUM_PE; k++) begin
      check({tag, "_pulses"}, pulse_cnt[k] - snap_cnt[k], 1);
      check({tag, "_latency"}, pulse_cyc[k], hs_cyc[k] + 1);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = '0; bus.cfg_par = 1'b0;
    bus.run_req = 1'b0; bus.run_abort = 1'b0; bus.iter_count = '0;
    s_in = {32'h4, 32'h3, 32'h2, 32'h1};
    cbg  = 32'hA5A5_0001;

    tick(3);
    check("rst_busy", bus.busy, 0);
    check("rst_cfg_ready", bus.cfg_ready, 0);
    check("rst_cfg_done", bus.cfg_done, 0);
    check("rst_init", dut.w_init, 0);
    @(negedge clk); rst = 1'b1;
    tick(2);

    // Back-to-back load: LSU then PE_0..PE_3 on consecutive cycles.
    snap();
    load(32'h11, 0, -1, NUM_PE + 1);
    check("b2b_cfg_done", bus.cfg_done, 1);
    check("b2b_last_word", dut.w_pe_config, 32'h15);
    tick(1);
    check_full_load("b2b");
    for (int k = 1; k <= NUM_PE; k++) check("b2b_consecutive", pulse_cyc[k], pulse_cyc[0] + k);

    // Gapped load from READY.
    snap();
    load(32'h21, 1, -1, NUM_PE + 1);
    tick(1);
    check_full_load("gap");
    check("gap_cfg_done", bus.cfg_done, 1);

    // Run of 3 cycles, then run_done one cycle after the last run cycle.
    snap();
    run(3, 0); tick(6);
    check("run3_cycles", run_cnt - snap_run, 3);
    check("run3_done", done_cnt - snap_done, 1);
    check("run3_done_when", done_cyc, last_run_cyc + 1);

    // iter_count 0 is ignored.
    snap();
    run(0, 0); tick(3);
    check("run0_cycles", run_cnt - snap_run, 0);
    check("run0_busy", bus.busy, 0);

    // Boundary: single-cycle run.
    snap();
    run(1, 0); tick(4);
    check("run1_cycles", run_cnt - snap_run, 1);
    check("run1_done", done_cnt - snap_done, 1);

    // Abort on the 4th of 10 cycles.
    snap();
    run(10, 4); tick(12);
    check("abort_cycles", run_cnt - snap_run, 4);
    check("abort_no_done", done_cnt - snap_done, 0);
    check("abort_ready", bus.cfg_done, 1);

    // Abort on the final count wins over run_done.
    snap();
    run(2, 2); tick(4);
    check("abort_last_cycles", run_cnt - snap_run, 2);
    check("abort_last_no_done", done_cnt - snap_done, 0);

    // cfg_start during RUN is ignored.
    snap();
    @(negedge clk); bus.run_req = 1'b1; bus.iter_count = CNT_W'(5);
    @(negedge clk); bus.run_req = 1'b0; bus.cfg_start = 1'b1;
    @(negedge clk); bus.cfg_start = 1'b0;
    tick(6);
    check("start_in_run_cycles", run_cnt - snap_run, 5);
    check("start_in_run_done", done_cnt - snap_done, 1);
    check("start_in_run_ready", bus.cfg_ready, 0);

    // Asynchronous reset right after word 2 is accepted.
    load(32'h41, 0, -1, 3);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_cfg_ready", bus.cfg_ready, 0);
    check("arst_init", dut.w_init, 0);
    check("arst_config", dut.w_pe_config, 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    snap();
    load(32'h51, 0, -1, NUM_PE + 1);
    check("reload_cfg_done", bus.cfg_done, 1);
    tick(1);
    check_full_load("reload");

`ifdef PE_ROW_CFG_PARITY_EN
    snap();
    load(32'h61, 0, 2, NUM_PE + 1);
    tick(2);
    check("par_lsu_pulse", pulse_cnt[0] - snap_cnt[0], 1);
    check("par_no_pe1_pulse", pulse_cnt[2] - snap_cnt[2], 0);
    check("par_err", bus.cfg_err, 1);
    check("par_idle_done", bus.cfg_done, 0);
    check("par_idle_busy", bus.busy, 0);
    snap();
    load(32'h71, 0, -1, NUM_PE + 1);
    check("par_err_cleared", bus.cfg_err, 0);
    check("par_reload_done", bus.cfg_done, 1);
`else
    snap();
    load(32'h61, 0, 2, NUM_PE + 1);
    tick(1);
    check("nopar_pe1_pulse", pulse_cnt[2] - snap_cnt[2], 1);
    check("nopar_err", bus.cfg_err, 0);
    check("nopar_done", bus.cfg_done, 1);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
